// File: rtl/alu_unit_pkg.sv
// Shared widths and internal opcode encodings for the integer execution unit.
package alu_unit_pkg;

    localparam int unsigned DAT_W     = 32;
    localparam int unsigned RAM_ADR_W = 32;
    localparam int unsigned ROB_BIT   = 4;
    localparam int unsigned OP_W      = 6;

    // Immediate forms share the R-form code; rs_ic_i selects the second operand.
    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 6'd0,
        OP_LUI   = 6'd1,
        OP_AUIPC = 6'd2,
        OP_JAL   = 6'd3,
        OP_JALR  = 6'd4,
        OP_BEQ   = 6'd5,
        OP_BNE   = 6'd6,
        OP_BLT   = 6'd7,
        OP_BGE   = 6'd8,
        OP_BLTU  = 6'd9,
        OP_BGEU  = 6'd10,
        OP_ADD   = 6'd11,
        OP_SUB   = 6'd12,
        OP_SLL   = 6'd13,
        OP_SLT   = 6'd14,
        OP_SLTU  = 6'd15,
        OP_XOR   = 6'd16,
        OP_SRL   = 6'd17,
        OP_SRA   = 6'd18,
        OP_OR    = 6'd19,
        OP_AND   = 6'd20
    } op_e;

    function automatic logic is_branch(input op_e op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLT) ||
               (op == OP_BGE) || (op == OP_BLTU) || (op == OP_BGEU);
    endfunction

endpackage

// File: rtl/alu_cmp.sv
// Combinational comparator shared by the branch and SLT/SLTU paths.
module alu_cmp #(
    parameter int unsigned DAT_W = 32
) (
    input  logic [DAT_W-1:0] a,
    input  logic [DAT_W-1:0] b,
    output logic             eq,
    output logic             lt_s,
    output logic             lt_u
);

    always_comb begin
        eq   = (a == b);
        lt_s = ($signed(a) < $signed(b));
        lt_u = (a < b);
    end

endmodule

// File: rtl/alu_unit.sv
// RV32I integer execution stage: computes result / next PC and broadcasts on the CDB one cycle later.
module alu_unit
    import alu_unit_pkg::*;
#(
    parameter int unsigned DAT_W     = alu_unit_pkg::DAT_W,
    parameter int unsigned RAM_ADR_W = alu_unit_pkg::RAM_ADR_W,
    parameter int unsigned ROB_BIT   = alu_unit_pkg::ROB_BIT,
    parameter int unsigned OP_W      = alu_unit_pkg::OP_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 br_flag,
    input  logic                 rs_en_i,
    input  logic [OP_W-1:0]      rs_op_i,
    input  logic                 rs_ic_i,
    input  logic [ROB_BIT-1:0]   rs_qd_i,
    input  logic [DAT_W-1:0]     rs_vs_i,
    input  logic [DAT_W-1:0]     rs_vt_i,
    input  logic [DAT_W-1:0]     rs_imm_i,
    input  logic [RAM_ADR_W-1:0] rs_pc_i,
    output logic                 cdb_en_o,
    output logic [ROB_BIT-1:0]   cdb_q_o,
    output logic [DAT_W-1:0]     cdb_v_o,
    output logic                 cdb_jump_o,
    output logic [RAM_ADR_W-1:0] cdb_npc_o
);

    op_e                  op;
    logic [DAT_W-1:0]     opb;
    logic [DAT_W-1:0]     cmp_b;
    logic [4:0]           shamt;
    logic                 eq, lt_s, lt_u;
    logic [RAM_ADR_W-1:0] pc4;
    logic [RAM_ADR_W-1:0] pc_imm;
    logic [RAM_ADR_W-1:0] jalr_sum;
    logic                 taken;
    logic [DAT_W-1:0]     res_v;
    logic                 res_jump;
    logic [RAM_ADR_W-1:0] res_npc;

    assign op     = op_e'(rs_op_i);
    assign opb    = rs_ic_i ? rs_vt_i : rs_imm_i;
    assign shamt  = opb[4:0];
    // Branches always compare against vt; ALU compares use the selected operand.
    assign cmp_b  = is_branch(op) ? rs_vt_i : opb;

    alu_cmp #(.DAT_W(DAT_W)) u_cmp (
        .a    (rs_vs_i),
        .b    (cmp_b),
        .eq   (eq),
        .lt_s (lt_s),
        .lt_u (lt_u)
    );

    assign pc4      = rs_pc_i + RAM_ADR_W'(4);
    assign pc_imm   = rs_pc_i + RAM_ADR_W'(rs_imm_i);
    assign jalr_sum = RAM_ADR_W'(rs_vs_i + rs_imm_i);

    always_comb begin
        taken = 1'b0;
        unique case (op)
            OP_BEQ:  taken = eq;
            OP_BNE:  taken = !eq;
            OP_BLT:  taken = lt_s;
            OP_BGE:  taken = !lt_s;
            OP_BLTU: taken = lt_u;
            OP_BGEU: taken = !lt_u;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        res_v    = '0;
        res_jump = 1'b0;
        res_npc  = pc4;
        case (op)
            OP_LUI:   res_v = rs_imm_i;
            OP_AUIPC: res_v = DAT_W'(pc_imm);
            OP_JAL: begin
                res_v    = DAT_W'(pc4);
                res_jump = 1'b1;
                res_npc  = pc_imm;
            end
            OP_JALR: begin
                res_v    = DAT_W'(pc4);
                res_jump = 1'b1;
                res_npc  = {jalr_sum[RAM_ADR_W-1:1], 1'b0};
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                res_jump = taken;
                res_npc  = taken ? pc_imm : pc4;
            end
            OP_ADD:  res_v = rs_vs_i + opb;
            OP_SUB:  res_v = rs_vs_i - opb;
            OP_SLL:  res_v = rs_vs_i << shamt;
            OP_SLT:  res_v = DAT_W'(lt_s);
            OP_SLTU: res_v = DAT_W'(lt_u);
            OP_XOR:  res_v = rs_vs_i ^ opb;
            OP_SRL:  res_v = rs_vs_i >> shamt;
            OP_SRA:  res_v = DAT_W'($signed(rs_vs_i) >>> shamt);
            OP_OR:   res_v = rs_vs_i | opb;
            OP_AND:  res_v = rs_vs_i & opb;
            default: res_v = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || br_flag) begin
            cdb_en_o   <= 1'b0;
            cdb_q_o    <= '0;
            cdb_v_o    <= '0;
            cdb_jump_o <= 1'b0;
            cdb_npc_o  <= '0;
        end else if (en) begin
            cdb_en_o <= rs_en_i;
            if (rs_en_i) begin
                cdb_q_o    <= rs_qd_i;
                cdb_v_o    <= res_v;
                cdb_jump_o <= res_jump;
                cdb_npc_o  <= res_npc;
            end
        end
    end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- Execution stage directly downstream of the reservation station.
- Accepts at most one ready instruction per cycle: opcode, operands, immediate, PC, destination ROB tag.
- Computes the RV32I integer result, and for branches and jumps the resolved next PC.
- Broadcasts the result on the CDB one cycle later; ROB, reservation station and LSB snoop the CDB to wake dependants and commit.

Parameters:
- DAT_W, 32, data/operand width.
- RAM_ADR_W, 32, PC width.
- ROB_BIT, 4, ROB tag width. Tag 0 is reserved as "no dependency".
- OP_W, 6, internal opcode width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  global stall; 0 freezes all state
- br_flag  in  1  mispredict flush from ROB
- rs_en_i  in  1  valid instruction from reservation station
- rs_op_i  in  OP_W  internal opcode
- rs_ic_i  in  1  0: second operand = imm; 1: second operand = vt
- rs_qd_i  in  ROB_BIT  destination ROB tag
- rs_vs_i  in  DAT_W  source operand 1
- rs_vt_i  in  DAT_W  source operand 2
- rs_imm_i  in  DAT_W  sign-extended immediate
- rs_pc_i  in  RAM_ADR_W  instruction PC
- cdb_en_o  out  1  result valid this cycle
- cdb_q_o  out  ROB_BIT  tag of result
- cdb_v_o  out  DAT_W  result value
- cdb_jump_o  out  1  instruction redirects (taken branch, JAL, JALR)
- cdb_npc_o  out  RAM_ADR_W  resolved next PC (pc+4 if not redirecting)

Behaviour:
- Reset/flush: when rst or br_flag is 1 at posedge, all outputs are cleared to 0.
- A flush discards any instruction presented in that same cycle.
- Flush has priority over en.
- Stall: when en=0 (and not flush), all output registers hold their values.
  - cdb_en_o stays asserted if it was asserted.
  - Consumers are also frozen by en, so there is no double-consume.
- Issue: when en=1 and rs_en_i=1, the result is registered.
  - Latency is exactly 1 cycle: cdb_en_o=1 in the following cycle with cdb_q_o=rs_qd_i.
  - There is no back-pressure; rs_en_i is accepted every enabled cycle.
- Idle: when en=1 and rs_en_i=0, cdb_en_o<=0.
  - The other outputs may keep stale values; they are don't-care while cdb_en_o=0.
- Operand select: B = rs_ic_i ? rs_vt_i : rs_imm_i.
- Arithmetic:
  - ADD/SUB, AND, OR and XOR are modulo 2^32.
  - SLT compares signed; SLTU compares unsigned. Both produce 0/1.
  - SLL/SRL/SRA use shamt = B[4:0]; SRA is arithmetic.
- LUI: v = imm.
- AUIPC: v = pc + imm.
- JAL: v = pc+4, jump=1, npc = pc+imm.
- JALR: v = pc+4, jump=1, npc = (vs+imm) & ~1.
- Branches BEQ/BNE/BLT/BGE/BLTU/BGEU compare vs with vt (always vt, regardless of ic).
  - v = 0.
  - If taken: jump=1, npc = pc+imm; otherwise jump=0, npc = pc+4.
- Non-control ops: jump=0, npc = pc+4.
- Undefined opcode: broadcast v=0, jump=0, so the ROB entry still completes and nothing deadlocks.
- Simultaneous flush and issue: the flush wins and no CDB broadcast is produced.
- Wrap-around: PC arithmetic wraps modulo 2^RAM_ADR_W and is not trapped.

Decomposition:
- Shared constants go in head.v alongside the existing macros: DAT_W, RAM_ADR_W, ROB_BIT and OP_W.
- Add one opcode macro per internal op to head.v: OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BEQ…OP_BGEU, OP_ADD…OP_AND (immediate forms share R-form codes and are selected by ic).
- One natural sub-module: alu_cmp, a combinational comparator returning eq, lt_s and lt_u.
  - Shared by the branch and SLT/SLTU paths.
- The rest stays in alu_unit: the compute case statement plus the output register.

Test Plan:
- Issue ADD with ic=1, vs=5, vt=7, qd=3 → next cycle cdb_en=1, q=3, v=12, jump=0, npc=pc+4; the cycle after, cdb_en=0.
- Issue SRA with ic=0, vs=0x80000000, imm=0x24 (shamt 4) → v=0xF8000000.
- Issue SLTU with vs=0xFFFFFFFF, vt=1 → v=0; SLT with the same operands → v=1.
- Issue BNE with vs=1, vt=2, pc=0x100, imm=-8 → jump=1, npc=0xF8, v=0; BEQ with the same operands → jump=0, npc=0x104.
- Issue JALR with pc=0x40, vs=0x1001, imm=2 → v=0x44, jump=1, npc=0x1002.
- Flush and stall sequence:
  - Issue ADD together with br_flag=1 → next cycle cdb_en=0.
  - Issue ADD, then hold en=0 for 3 cycles → cdb_en, q and v stay constant throughout.
  - Raise rst mid-stall → all outputs become 0 the next cycle.
